freq_gate_controller: RTL

FREQ_GATE_CONTROLLER -- requirements
Module: freq_gate_controller

---
 rtl/freq_counter_pkg.sv | 27 ++
 rtl/freq_gate_controller_gate_timer.sv | 48 ++++
 rtl/freq_gate_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/freq_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : freq_counter_pkg                                           |
// | Purpose  : Shared types and helpers for the frequency-counter gate    |
// |            controller: FSM state enum and gate-length computation.    |
// | Contents : gate_state_t  - controller states                         |
// |            gate_ticks()  - clock cycles in one gate window           |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package freq_counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_VALID = 3'd4
  } gate_state_t;

  // Divide before multiplying so large clock rates with long windows
  // stay inside 32-bit integer arithmetic.
  function automatic int gate_ticks(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_gate_controller_gate_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gate_timer                                                 |
// | Purpose  : Down-counter that times the gate window. Loads a constant, |
// |            decrements on request and saturates at zero.               |
// | Ports    : clk_in      - system clock (rising edge)                   |
// |            reset_n_in  - asynchronous active-low reset (count -> 0)   |
// |            load_in     - load LOAD_VALUE (has priority over dec_in)   |
// |            dec_in      - decrement by one while non-zero              |
// |            zero_out    - count is zero                                |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module gate_timer #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic load_in,
  input  logic dec_in,
  output logic zero_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Saturating decrement: the counter never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = LOAD_VALUE;
    end else if (dec_in && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_out = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/freq_gate_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : freq_gate_controller                                       |
// | Purpose  : Sequences one frequency measurement: clear the BCD digit   |
// |            chain, open the gate for GATE_TICKS cycles, strobe the     |
// |            result register, then hold result_valid until accepted.    |
// | Ports    : clk_in, reset_n_in (async, active low)                     |
// |            start_in, abort_in, overflow_in, result_ready_in           |
// |            counter_clear_out, counter_enable_out, latch_out,          |
// |            result_valid_out, overflow_out, busy_out                   |
// | Config   : FREQ_GATE_AUTO_RUN_EN - when defined, an accepted result   |
// |            immediately starts the next measurement.                   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module freq_gate_controller
  import freq_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int GATE_MS     = 1000
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic start_in,
  input  logic abort_in,
  input  logic overflow_in,
  input  logic result_ready_in,
  output logic counter_clear_out,
  output logic counter_enable_out,
  output logic latch_out,
  output logic result_valid_out,
  output logic overflow_out,
  output logic busy_out
);

  localparam int GATE_TICKS = gate_ticks(CLK_FREQ_HZ, GATE_MS);
  localparam int TIMER_W    = $clog2(GATE_TICKS);

  gate_state_t state_q;
  gate_state_t state_d;
  logic        sticky_q;
  logic        sticky_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        timer_zero;

  // Timer is loaded with GATE_TICKS-1 during CLEAR, so GATE sees counts
  // GATE_TICKS-1 down to 0: exactly GATE_TICKS enabled cycles.
  gate_timer #(
    .WIDTH      (TIMER_W),
    .LOAD_VALUE (TIMER_W'(GATE_TICKS - 1))
  ) u_gate_timer (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .load_in    (state_q == ST_CLEAR),
    .dec_in     (state_q == ST_GATE),
    .zero_out   (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_in) state_d = ST_CLEAR;
      ST_CLEAR: state_d = abort_in ? ST_IDLE : ST_GATE;
      // Abort wins over expiry so an aborted run never strobes the latch.
      ST_GATE: begin
        if (abort_in) begin
          state_d = ST_IDLE;
        end else if (timer_zero) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: state_d = ST_VALID;
      ST_VALID: begin
        if (result_ready_in) begin
`ifdef FREQ_GATE_AUTO_RUN_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow collects digit-chain carries across the gate window;
  // the visible flag only changes when a result is latched, so aborted
  // runs leave the previous result's flag intact.
  always_comb begin
    sticky_d   = sticky_q;
    overflow_d = overflow_q;
    if (state_q == ST_CLEAR) begin
      sticky_d = 1'b0;
    end else if ((state_q == ST_GATE) && overflow_in) begin
      sticky_d = 1'b1;
    end
    if (state_q == ST_LATCH) begin
      overflow_d = sticky_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      sticky_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
    end
  end

  assign counter_clear_out  = (state_q == ST_CLEAR);
  assign counter_enable_out = (state_q == ST_GATE);
  assign latch_out          = (state_q == ST_LATCH);
  assign result_valid_out   = (state_q == ST_VALID);
  assign overflow_out       = overflow_q;
  assign busy_out           = (state_q != ST_IDLE);

endmodule
`default_nettype wire
